// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative MULT/MULTU/DIV/DIVU sequencer for the MIPS32 HI/LO pair.
// Each operation takes one load cycle, WIDTH shift-add or restoring-divide steps, a sign-fix
// cycle, and a single write cycle in which HI/LO capture the result.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             hi_we,
    output logic             lo_we,
    output logic [WIDTH-1:0] hi_d,
    output logic [WIDTH-1:0] lo_d
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_WRITE} state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic           is_div;
    logic           neg_q;      // product sign (multiply) or quotient sign (divide)
    logic           neg_r;      // remainder sign follows the dividend
    logic           div_zero;
    logic [WIDTH-1:0] acc;      // product high half, or partial remainder
    logic [WIDTH-1:0] low;      // multiplier / product low half, or dividend / quotient
    logic [WIDTH-1:0] opnd;     // multiplicand magnitude, or divisor magnitude
    logic [WIDTH-1:0] a_raw;    // untouched dividend, returned as HI on divide by zero

    logic [WIDTH:0] sum_c;
    logic [WIDTH:0] shifted_c;
    logic [WIDTH:0] diff_c;
    logic           accept;

    // Magnitude of an operand; only signed ops with a negative value are negated.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? -v : v;
    endfunction

    // Two's-complement sign correction of a result field.
    function automatic logic [WIDTH-1:0] fix_w(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] fix_2w(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    // The WRITE cycle also accepts a request so back-to-back operations lose no cycle.
    assign accept = start && (state == S_IDLE || state == S_WRITE);

    // One iteration step: carry-preserving add for multiply, trial subtract for divide.
    always_comb begin
        sum_c     = {1'b0, acc} + (low[0] ? {1'b0, opnd} : '0);
        shifted_c = {acc, low[WIDTH-1]};
        diff_c    = shifted_c - {1'b0, opnd};
    end

    // Sequencer FSM with registered strobes and result data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi_we <= 1'b0;
            lo_we <= 1'b0;
            hi_d  <= '0;
            lo_d  <= '0;
        end else begin
            done  <= 1'b0;
            hi_we <= 1'b0;
            lo_we <= 1'b0;
            case (state)
                S_CALC: begin
                    if (is_div) begin
                        if (!diff_c[WIDTH]) begin
                            acc <= diff_c[WIDTH-1:0];
                            low <= {low[WIDTH-2:0], 1'b1};
                        end else begin
                            acc <= shifted_c[WIDTH-1:0];
                            low <= {low[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc <= sum_c[WIDTH:1];
                        low <= {sum_c[0], low[WIDTH-1:1]};
                    end
                    cnt <= cnt - CW'(1);
                    if (cnt == '0) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (div_zero) begin
                        hi_d <= a_raw;
                        lo_d <= '1;
                    end else if (is_div) begin
                        hi_d <= fix_w(acc, neg_r);
                        lo_d <= fix_w(low, neg_q);
                    end else begin
                        {hi_d, lo_d} <= fix_2w({acc, low}, neg_q);
                    end
                    done  <= 1'b1;
                    hi_we <= 1'b1;
                    lo_we <= 1'b1;
                    state <= S_WRITE;
                end
                S_WRITE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
            if (accept) begin
                is_div   <= op[1];
                neg_q    <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_r    <= op[0] & a[WIDTH-1];
                div_zero <= op[1] & (b == '0);
                acc      <= '0;
                low      <= mag(a, op[0]);
                opnd     <= mag(b, op[0]);
                a_raw    <= a;
                cnt      <= CW'(WIDTH - 1);
                busy     <= 1'b1;
                state    <= S_CALC;
            end
        end
    end

endmodule
